// File: rtl/multdiv_seq_pkg.sv
// rtl/multdiv_seq_pkg.sv - shared encodings and constants for the multiply/divide unit
package multdiv_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MULT = 2'b01,
      DIV  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [5:0]  MULT_ITER = 6'd16;
   localparam logic [5:0]  DIV_ITER  = 6'd32;
   localparam logic [31:0] INT_MIN   = 32'h80000000;

   // Unsigned magnitude; INT_MIN maps to 0x80000000, which still fits.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/multdiv_seq_booth_recode.sv
// rtl/multdiv_seq_booth_recode.sv - radix-4 Booth digit to addend, negation as invert plus carry-in
module booth_recode (
   input  logic [2:0]  window,
   input  logic [32:0] m,
   output logic [32:0] addend,
   output logic        cin
);

   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (window)
         3'b001, 3'b010: addend = m;
         3'b011:         addend = {m[31:0], 1'b0};
         3'b100: begin
            addend = ~{m[31:0], 1'b0};
            cin    = 1'b1;
         end
         3'b101, 3'b110: begin
            addend = ~m;
            cin    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - multi-cycle signed multiply (radix-4 Booth) and divide (restoring)
module multdiv_seq
   import multdiv_seq_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   state_t      state;
   logic [5:0]  cnt;
   logic [32:0] mcand;
   logic [65:0] acc;
   logic [32:0] rem;
   logic [31:0] quo;
   logic [31:0] absb;
   logic        neg;
   logic        bzero;

   logic [32:0] booth_addend;
   logic        booth_cin;
   logic [32:0] add_a, add_b;
   logic        add_cin;
   logic [33:0] sum;
   logic [32:0] rem_sh;
   logic [65:0] acc_nx;
   logic [32:0] rem_nx;
   logic [31:0] quo_nx;
   logic [31:0] quo_fix;

   booth_recode u_booth (
      .window (acc[2:0]),
      .m      (mcand),
      .addend (booth_addend),
      .cin    (booth_cin)
   );

   assign rem_sh = {rem[31:0], quo[31]};

   // One extra sign bit keeps the rare +2^32 partial (INT_MIN times -2) exact before the shift.
   always_comb begin
      add_a   = acc[65:33];
      add_b   = booth_addend;
      add_cin = booth_cin;
      if (state == DIV) begin
         add_a   = rem_sh;
         add_b   = ~{1'b0, absb};
         add_cin = 1'b1;
      end
   end

   assign sum    = {add_a[32], add_a} + {add_b[32], add_b} + {33'd0, add_cin};
   assign acc_nx = {sum[33], sum, acc[32:2]};
   assign rem_nx = sum[33] ? rem_sh : sum[32:0];
   assign quo_nx = {quo[30:0], ~sum[33]};
   assign quo_fix = neg ? (32'd0 - quo_nx) : quo_nx;

   assign data_resultRDY = (state == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         mcand          <= '0;
         acc            <= '0;
         rem            <= '0;
         quo            <= '0;
         absb           <= '0;
         neg            <= 1'b0;
         bzero          <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (ctrl_MULT) begin
         state <= MULT;
         cnt   <= '0;
         mcand <= {data_operandA[31], data_operandA};
         acc   <= {33'd0, data_operandB, 1'b0};
      end else if (ctrl_DIV) begin
         state <= DIV;
         cnt   <= '0;
         rem   <= '0;
         quo   <= abs32(data_operandA);
         absb  <= abs32(data_operandB);
         neg   <= data_operandA[31] ^ data_operandB[31];
         bzero <= (data_operandB == 32'd0);
      end else begin
         case (state)
            MULT: begin
               acc <= acc_nx;
               cnt <= cnt + 6'd1;
               if (cnt == MULT_ITER - 6'd1) begin
                  state          <= DONE;
                  data_result    <= acc_nx[32:1];
                  data_exception <= ~((&acc_nx[64:32]) | ~(|acc_nx[64:32]));
               end
            end
            DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 6'd1;
               if (cnt == DIV_ITER - 6'd1) begin
                  state <= DONE;
                  if (bzero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else begin
                     // A positive-signed magnitude of 2^31 only arises from INT_MIN / -1.
                     data_result    <= quo_fix;
                     data_exception <= ~neg & quo_nx[31];
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Multi-cycle signed multiply/divide unit in the execute stage. It sits beside the ALU and takes the same operand A/B buses from the decode/execute latch. It produces a 32-bit result with an exception flag and a one-cycle ready strobe, which the pipeline stall logic consumes. Multiply uses radix-4 Booth over 16 iterations. Divide uses a restoring shift-subtract over 32 iterations with sign fix-up.

## Interface
Parameters:
- none. Widths are fixed at 32 bits, matching the ALU datapath.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- data_operandA  in  32  multiplicand or dividend, two's complement.
- data_operandB  in  32  multiplier or divisor, two's complement.
- ctrl_MULT  in  1  single-cycle start pulse for multiply.
- ctrl_DIV  in  1  single-cycle start pulse for divide.
- data_result  out  32  low 32 bits of the product, or the quotient.
- data_exception  out  1  overflow or divide-by-zero; valid while data_resultRDY is high.
- data_resultRDY  out  1  high for exactly one cycle when the result is valid.

## Operation
- States: IDLE, MULT, DIV, DONE. Iteration counter is 6 bits.
- Start: at an edge where ctrl_MULT or ctrl_DIV is high:
  - operands latched, counter cleared;
  - state goes to MULT or DIV.
  - If both pulses are high, MULT wins.
- A start pulse in any state, including MULT, DIV or DONE, aborts current work and restarts with the new operands.
  - If the pulse arrives in DONE, the old result still shows RDY=1 in that cycle.
- MULT iterations:
  - 66-bit accumulator: {33-bit partial, 32-bit multiplier, 1-bit Booth guard}.
  - Each edge decodes 3 multiplier bits into a digit of 0, ±M or ±2M (M = sign-extended multiplicand, 33 bits).
  - The digit is added to the partial, then the accumulator is arithmetic-shifted right by 2.
  - 16 iterations.
- MULT exception: set when the full 64-bit product is not the sign extension of its bit 31.
  - Example: 0x80000000 × 0xFFFFFFFF gives result 0x80000000 with exception=1.
- DIV iterations:
  - Magnitudes are taken at start. Remainder register is 33 bits, quotient register 32 bits.
  - Each edge shifts {rem,quo} left by 1, trial-subtracts |B|, and keeps the difference if it is non-negative, setting quotient bit 0.
  - 32 iterations.
- DIV fix-up on entry to DONE: quotient is negated if sign(A) XOR sign(B). Truncation is toward zero; the remainder is discarded.
- Divide by zero: latency unchanged. Result is 0x00000000, exception=1.
- 0x80000000 ÷ 0xFFFFFFFF: result 0x80000000, exception=1.
- DONE:
  - RDY=1 for one cycle, then IDLE at the next edge.
  - data_result and data_exception hold their values until the next start pulse or reset.

## Timing
- Start pulse sampled at edge k.
- MULT latency:
  - MULT occupies edges k+1..k+16; DONE is entered at edge k+16.
  - RDY is high in the cycle after edge k+16, i.e. 16 cycles after the start edge.
- DIV latency:
  - DIV occupies edges k+1..k+32.
  - RDY is high in the cycle after edge k+32.
- Latency is fixed and independent of operand values, including the divide-by-zero case.
- data_result and data_exception change only on the edge that enters DONE, or on reset.
- The data outputs are registered. The ready strobe is decoded from the state register, with no combinational path from the inputs.
- Operand inputs are ignored except at a start edge.
- Reset (asynchronous, at any time, including mid-iteration):
  - state=IDLE, counter=0;
  - data_result=0x00000000, data_exception=0, data_resultRDY=0.
  - The first start pulse after reset deassertion behaves normally.

## Structure
- Shared package contains:
  - state encoding constants (IDLE=2'b00, MULT=2'b01, DIV=2'b10, DONE=2'b11);
  - MULT_ITER=16 and DIV_ITER=32;
  - INT_MIN=32'h80000000.
- One natural sub-module, booth_recode:
  - input: 3-bit window plus 33-bit M;
  - output: 33-bit addend and a carry-in for negation.
- The control FSM, counter, datapath registers and the 33-bit add/subtract stay in the top module.
  - The add/subtract is shared between MULT and DIV.

## Test plan
- 7 × -3 via ctrl_MULT:
  - RDY exactly 16 cycles after the start edge;
  - result 0xFFFFFFEB, exception=0.
- 0x00010000 × 0x00010000:
  - result 0x00000000, exception=1.
- Signed divides:
  - -100 ÷ 7 → 0xFFFFFFF2 (-14), exception=0, RDY 32 cycles after start;
  - 100 ÷ -7 → -14.
- Divide exceptions:
  - 5 ÷ 0 → result 0, exception=1, RDY still at 32 cycles;
  - 0x80000000 ÷ -1 → 0x80000000, exception=1.
- Abort and simultaneous pulses:
  - ctrl_DIV pulse, then ctrl_MULT at cycle 10 with 3 × 4 → RDY 16 cycles after the second pulse, result 12, no earlier RDY;
  - simultaneous ctrl_MULT and ctrl_DIV with 6, 3 → result 18.
- Reset mid-operation:
  - reset asserted at cycle 8 of a MULT → all outputs 0 immediately, no RDY afterwards;
  - RDY stays low until a new pulse arrives, which then completes normally.
